// File: rtl/result_piso.sv
// result_piso: parallel-in / serial-out drain for the systolic-array result
// matrix. A capture strobe snapshots all N*M accumulators at once; the
// controller's send signal then paces a row-major valid/ready stream of the
// elements, each tagged with its row, column and a last flag. rst_piso
// rewinds the stream to element 0 without discarding the captured data.
module result_piso #(
  parameter  int N  = 3,
  parameter  int M  = 3,
  parameter  int DW = 32,
  localparam int RW = (N > 1) ? $clog2(N) : 1,
  localparam int CW = (M > 1) ? $clog2(M) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_rst_piso,
  input  logic                i_capture,
  input  logic [N*M*DW-1:0]   i_results_in,
  input  logic                i_send,
  input  logic                i_out_ready,
  output logic                o_out_valid,
  output logic [DW-1:0]       o_out_data,
  output logic [RW-1:0]       o_out_row,
  output logic [CW-1:0]       o_out_col,
  output logic                o_out_last,
  output logic                o_done,
  output logic                o_busy,
  output logic                o_overflow_err
);

  localparam int NM = N * M;
  localparam int IW = (NM > 1) ? $clog2(NM) : 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(NM - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(M - 1);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_READY  = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  // Captured result matrix; element k lives at r_mem[k].
  logic [NM-1:0][DW-1:0] r_mem;

  state_t        r_state;
  logic [IW-1:0] r_ptr;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          r_valid;
  logic [DW-1:0] r_data;
  logic          r_last;
  logic          r_done;
  logic          r_busy;
  logic          r_ovf;

  state_t        w_state_nxt;
  logic [IW-1:0] w_ptr_nxt;
  logic [RW-1:0] w_row_nxt;
  logic [CW-1:0] w_col_nxt;
  logic          w_valid_nxt;
  logic [DW-1:0] w_data_nxt;
  logic          w_last_nxt;
  logic          w_done_nxt;
  logic          w_busy_nxt;
  logic          w_ovf_nxt;
  logic          w_load;
  logic          w_xfer;

  assign w_xfer = r_valid & i_out_ready;

  // Next-state, pointer and output decode; row/col step as counters so no
  // divider is needed to tag each element.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_valid_nxt = r_valid;
    w_done_nxt  = 1'b0;
    w_ovf_nxt   = 1'b0;
    w_load      = 1'b0;

    if (i_rst_piso) begin
      // Stream clear wins over send and the handshake; a pending beat is
      // dropped but the buffer survives so the next send restarts at 0.
      w_ptr_nxt   = '0;
      w_row_nxt   = '0;
      w_col_nxt   = '0;
      w_valid_nxt = 1'b0;
      if (i_capture) begin
        w_load      = 1'b1;
        w_state_nxt = ST_READY;
      end else if (r_state == ST_STREAM) begin
        w_state_nxt = ST_READY;
      end else begin
        w_state_nxt = r_state;
      end
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (i_capture) begin
            w_load      = 1'b1;
            w_state_nxt = ST_READY;
            w_ptr_nxt   = '0;
            w_row_nxt   = '0;
            w_col_nxt   = '0;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end

        ST_READY: begin
          if (i_capture) begin
            // Fresh results overwrite the held set before streaming starts.
            w_load      = 1'b1;
            w_state_nxt = ST_READY;
            w_ptr_nxt   = '0;
            w_row_nxt   = '0;
            w_col_nxt   = '0;
          end else if (i_send) begin
            w_state_nxt = ST_STREAM;
            w_valid_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_READY;
          end
        end

        ST_STREAM: begin
          // The buffer is in use, so a capture now is refused and flagged.
          w_ovf_nxt = i_capture;
          if (w_xfer) begin
            if (r_ptr == LAST_IDX) begin
              w_state_nxt = ST_EMPTY;
              w_ptr_nxt   = '0;
              w_row_nxt   = '0;
              w_col_nxt   = '0;
              w_valid_nxt = 1'b0;
              w_done_nxt  = 1'b1;
            end else begin
              w_ptr_nxt   = r_ptr + IW'(1);
              w_valid_nxt = i_send;
              if (r_col == LAST_COL) begin
                w_col_nxt = '0;
                if (r_row == LAST_ROW) begin
                  w_row_nxt = '0;
                end else begin
                  w_row_nxt = r_row + RW'(1);
                end
              end else begin
                w_col_nxt = r_col + CW'(1);
                w_row_nxt = r_row;
              end
            end
          end else if (!r_valid) begin
            // Paused between beats: resume on the current pointer.
            w_valid_nxt = i_send;
          end else begin
            // Stalled beat: everything holds until accepted.
            w_valid_nxt = 1'b1;
          end
        end

        default: begin
          w_state_nxt = ST_EMPTY;
          w_ptr_nxt   = '0;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
          w_valid_nxt = 1'b0;
        end
      endcase
    end

    if (w_valid_nxt) begin
      w_data_nxt = r_mem[w_ptr_nxt];
    end else begin
      w_data_nxt = {DW{1'b0}};
    end
    w_last_nxt = w_valid_nxt & (w_ptr_nxt == LAST_IDX);
    w_busy_nxt = (w_state_nxt == ST_STREAM);
  end

  // State, pointer and registered output updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_ptr   <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_valid <= 1'b0;
      r_data  <= {DW{1'b0}};
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
      r_last  <= w_last_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // Result buffer load; contents need no reset since they are only read
  // after a capture has filled them.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_mem <= i_results_in;
    end else begin
      r_mem <= r_mem;
    end
  end

  assign o_out_valid    = r_valid;
  assign o_out_data     = r_data;
  assign o_out_row      = r_row;
  assign o_out_col      = r_col;
  assign o_out_last     = r_last;
  assign o_done         = r_done;
  assign o_busy         = r_busy;
  assign o_overflow_err = r_ovf;

endmodule

// File: doc/result_piso.md
Name: result_piso

Overview:
- Parallel-in/serial-out result drain sitting directly downstream of the systolic-array controller.
- Captures the full N×M result matrix from the PE accumulators in one cycle.
- Streams the results out one element per beat, in row-major order, over a valid/ready interface.
- The controller's `send` and `rst_piso` outputs pace and clear the stream.

Parameters:
- N, 3, rows of result matrix C (rows of A)
- M, 3, columns of result matrix C (columns of B)
- DW, 32, width of one result element
- Derived IW = max(1, $clog2(N*M)); RW = max(1, $clog2(N)); CW = max(1, $clog2(M))

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rst_piso  in  1  synchronous stream clear from controller
- capture  in  1  one-cycle strobe: load results_in into buffer
- results_in  in  N*M*DW  element k = r*M+c at bits [k*DW +: DW]
- send  in  1  stream enable from controller (SEND state)
- out_ready  in  1  downstream accept
- out_valid  out  1  out_data holds a valid element
- out_data  out  DW  current element
- out_row  out  RW  row index of current element
- out_col  out  CW  column index of current element
- out_last  out  1  current element is k = N*M-1
- done  out  1  one-cycle pulse after the last element is accepted
- busy  out  1  state == STREAM
- overflow_err  out  1  one-cycle pulse: capture rejected

Behaviour:
- All outputs are registered.
- Async rst: state EMPTY, pointer/row/col = 0, every output = 0, buffer contents don't-care.
- States:
  - EMPTY: no data held.
  - READY: data held, pointer at 0.
  - STREAM: draining.
- capture:
  - Honoured in EMPTY and READY: loads all N*M elements, pointer = 0, goes to READY next cycle.
  - In READY it overwrites the buffer.
  - In STREAM it is ignored: buffer unchanged, overflow_err = 1 for one cycle.
- READY → STREAM when send = 1 and rst_piso = 0. out_valid = 1 with element 0 on the next cycle (1-cycle latency from send).
- STREAM handshake:
  - A transfer occurs when out_valid && out_ready.
  - While out_valid && !out_ready, out_data, out_row, out_col and out_last hold stable regardless of send.
  - After a transfer of a non-last element: pointer increments; col wraps M-1 → 0 and increments row.
  - After that transfer, out_valid next cycle equals send. With send = 0 the block stays in STREAM with out_valid = 0. It reasserts out_valid one cycle after send returns, presenting the next element with no skip or duplicate.
  - After the transfer of the last element: out_valid = 0, done = 1 for one cycle, state → EMPTY, pointer/row/col = 0.
- out_last = 1 exactly while the presented element has k = N*M-1.
- rst_piso = 1 (any state, priority over send and the handshake):
  - out_valid = 0 and pointer/row/col = 0 next cycle.
  - STREAM → READY; data retained, so a later send restarts at element 0. EMPTY stays EMPTY.
  - A pending un-accepted beat is dropped.
  - capture in the same cycle is still honoured (→ READY).
- Row/column are tracked with counters; no division.
- Pointer never exceeds N*M-1.
- N*M = 1: the first beat is the last and done follows its acceptance.

Test Plan:
- (N=M=3, DW=32, element k = 0x100+k.)
- Assert rst mid-stream → all outputs 0 immediately. State EMPTY; send has no effect until capture.
- capture, then send = 1 and out_ready = 1 held → out_valid rises 1 cycle after send. Nine consecutive beats 0x100..0x108 with (row, col) = (0,0)..(2,2); out_last only on 0x108; done pulses the cycle after; busy low after.
- Hold out_ready = 0 for 3 cycles while 0x102 is presented → out_data, row and col stay stable; then 0x103 follows with no duplicate or skip.
- Drop send after 0x104 is accepted → out_valid = 0 next cycle. Raise send 4 cycles later → 0x105 appears 1 cycle after.
- rst_piso after 0x105 is accepted → out_valid = 0 next cycle and busy = 0. Raise send → stream restarts at 0x100 and all 9 beats complete.
- Pulse capture with new data during STREAM → overflow_err for one cycle; streamed values remain the original 0x10x set.
